// File: rtl/vlcenc_if.sv
// Token and word ports of the vlcenc VLC stage, grouped as one bundle.
// Handshake: a token moves when h_en && h_rdy at a rising edge; a word moves when o_valid && o_rdy at a rising edge.
interface vlcenc_if;
  logic        h_rdy;
  logic        h_en;
  logic [15:0] h_val;
  logic [5:0]  h_len;
  logic        h_end;
  logic        h_dc;
  logic        dc_clr;
  logic        flush;
  logic [15:0] o_data;
  logic        o_valid;
  logic        o_rdy;

  modport master (
    input  h_rdy,
    output h_en, h_val, h_len, h_end, h_dc, dc_clr, flush,
    input  o_data, o_valid,
    output o_rdy
  );

  modport slave (
    output h_rdy,
    input  h_en, h_val, h_len, h_end, h_dc, dc_clr, flush,
    output o_data, o_valid,
    input  o_rdy
  );
endinterface

// File: rtl/vlcenc.sv
// MPEG-2 intra VLC stage: DC prediction, DC size / escape AC / EOB coding, MSB-first 16-bit packing.
// Optional VLCENC_SHORTCODE_EN adds the three shortest B.14 AC codes.
module vlcenc (
  input  logic        clk,
  input  logic        reset_n,
  vlcenc_if.slave     bus,
  output logic [1:0]  dbg_state,
  output logic [5:0]  dbg_fill,
  output logic [15:0] dbg_pred
);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_CODE = 2'd1, S_APPEND = 2'd2} state_t;
  typedef enum logic [1:0] {K_AC = 2'd0, K_DC = 2'd1, K_END = 2'd2} kind_t;

  state_t      state_q, state_d;
  logic        live_q;
  logic        rdy;
  kind_t       kind_q;
  logic [15:0] val_q;
  logic [5:0]  run_q;
  logic        pad_q;
  logic [23:0] code_q;
  logic [4:0]  clen_q;
  logic [15:0] pred_q;
  logic [47:0] acc_q;
  logic [5:0]  fill_q;

  logic        accept, flush_req;
  logic        drain, room, do_app;
  logic [3:0]  pad_len;
  logic [4:0]  app_len;
  logic [5:0]  fill_b;
  logic [6:0]  total, shamt;
  logic [47:0] acc_b, ins;

  logic [23:0]        code_c;
  logic [4:0]         clen_c;
  logic signed [16:0] dc_diff_w;
  logic signed [11:0] dc_diff;
  logic [10:0]        dc_mag, dc_mask, dc_bits;
  logic [3:0]         dc_size;
  logic [8:0]         pfx;
  logic [3:0]         pfx_len;
  logic signed [11:0] ac_lev;
`ifdef VLCENC_SHORTCODE_EN
  logic [10:0]        ac_mag;
`endif

  assign accept    = bus.h_en && rdy;
  assign flush_req = bus.flush && rdy && !bus.h_en;

  // ---------------- FSM ----------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (accept)         state_d = S_CODE;
        else if (flush_req) state_d = S_APPEND;
      end
      S_CODE:   state_d = S_APPEND;
      S_APPEND: if (room) state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // live_q keeps h_rdy low until the first edge after reset release
  always_comb begin
    rdy       = live_q && (state_q == S_IDLE);
    bus.h_rdy = rdy;
    dbg_state = state_q;
  end

  // ---------------- token capture and code register ----------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      live_q <= 1'b0;
      kind_q <= K_AC;
      val_q  <= 16'd0;
      run_q  <= 6'd0;
      pad_q  <= 1'b0;
      code_q <= 24'd0;
      clen_q <= 5'd0;
    end else begin
      live_q <= 1'b1;
      if (accept) begin
        kind_q <= bus.h_end ? K_END : (bus.h_dc ? K_DC : K_AC);
        val_q  <= bus.h_val;
        run_q  <= bus.h_len;
        pad_q  <= 1'b0;
      end else if (flush_req) begin
        pad_q  <= 1'b1;
      end
      if (state_q == S_CODE) begin
        code_q <= code_c;
        clen_q <= clen_c;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                                 pred_q <= 16'd0;
    else if (bus.dc_clr)                          pred_q <= 16'd0;
    else if (state_q == S_CODE && kind_q == K_DC) pred_q <= val_q;
  end

  // ---------------- codeword formation ----------------
  always_comb begin
    dc_diff_w = $signed({val_q[15], val_q}) - $signed({pred_q[15], pred_q});
    if (dc_diff_w > 17'sd2047)       dc_diff = 12'sd2047;
    else if (dc_diff_w < -17'sd2047) dc_diff = -12'sd2047;
    else                             dc_diff = dc_diff_w[11:0];
    dc_mag = dc_diff[11] ? (~dc_diff[10:0] + 11'd1) : dc_diff[10:0];

    dc_size = 4'd0;
    for (int i = 0; i < 11; i++) begin
      if (dc_mag[i]) dc_size = 4'(i + 1);
    end

    // negative diffs are sent as diff + 2^size - 1 (ones' complement of |diff|)
    dc_mask = (11'd1 << dc_size) - 11'd1;
    dc_bits = dc_diff[11] ? (dc_diff[10:0] + dc_mask) : dc_diff[10:0];

    case (dc_size)
      4'd0:    begin pfx = 9'b100;       pfx_len = 4'd3; end
      4'd1:    begin pfx = 9'b00;        pfx_len = 4'd2; end
      4'd2:    begin pfx = 9'b01;        pfx_len = 4'd2; end
      4'd3:    begin pfx = 9'b101;       pfx_len = 4'd3; end
      4'd4:    begin pfx = 9'b110;       pfx_len = 4'd3; end
      4'd5:    begin pfx = 9'b1110;      pfx_len = 4'd4; end
      4'd6:    begin pfx = 9'b11110;     pfx_len = 4'd5; end
      4'd7:    begin pfx = 9'b111110;    pfx_len = 4'd6; end
      4'd8:    begin pfx = 9'b1111110;   pfx_len = 4'd7; end
      4'd9:    begin pfx = 9'b11111110;  pfx_len = 4'd8; end
      4'd10:   begin pfx = 9'b111111110; pfx_len = 4'd9; end
      default: begin pfx = 9'b111111111; pfx_len = 4'd9; end
    endcase

    if ($signed(val_q) > 16'sd2047)       ac_lev = 12'sd2047;
    else if ($signed(val_q) < -16'sd2047) ac_lev = -12'sd2047;
    else if (val_q == 16'd0)              ac_lev = 12'sd1;
    else                                  ac_lev = val_q[11:0];

    case (kind_q)
      K_END: begin
        code_c = 24'd2;
        clen_c = 5'd2;
      end
      K_DC: begin
        code_c = ({15'd0, pfx} << dc_size) | {13'd0, dc_bits};
        clen_c = {1'b0, pfx_len} + {1'b0, dc_size};
      end
      default: begin
        code_c = {6'b000001, run_q, ac_lev};
        clen_c = 5'd24;
`ifdef VLCENC_SHORTCODE_EN
        ac_mag = ac_lev[11] ? (~ac_lev[10:0] + 11'd1) : ac_lev[10:0];
        if (run_q == 6'd0 && ac_mag == 11'd1) begin
          code_c = {21'd0, 2'b11, ac_lev[11]};
          clen_c = 5'd3;
        end else if (run_q == 6'd1 && ac_mag == 11'd1) begin
          code_c = {20'd0, 3'b011, ac_lev[11]};
          clen_c = 5'd4;
        end else if (run_q == 6'd0 && ac_mag == 11'd2) begin
          code_c = {19'd0, 4'b0100, ac_lev[11]};
          clen_c = 5'd5;
        end
`endif
      end
    endcase
  end

  // ---------------- accumulator ----------------
  // Drain and merge may share an edge; the merge position accounts for the drained word.
  always_comb begin
    drain   = (fill_q >= 6'd16) && bus.o_rdy;
    pad_len = 4'd0 - fill_q[3:0];
    app_len = pad_q ? {1'b0, pad_len} : clen_q;
    fill_b  = drain ? (fill_q - 6'd16) : fill_q;
    total   = {1'b0, fill_b} + {2'b00, app_len};
    room    = (total <= 7'd48);
    do_app  = (state_q == S_APPEND) && room;
    shamt   = 7'd48 - total;
    acc_b   = drain ? {acc_q[31:0], 16'd0} : acc_q;
    ins     = pad_q ? 48'd0 : ({24'd0, code_q} << shamt);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      acc_q  <= 48'd0;
      fill_q <= 6'd0;
    end else begin
      acc_q  <= do_app ? (acc_b | ins) : acc_b;
      fill_q <= do_app ? total[5:0] : fill_b;
    end
  end

  assign bus.o_data  = acc_q[47:32];
  assign bus.o_valid = (fill_q >= 6'd16);
  assign dbg_fill    = fill_q;
  assign dbg_pred    = pred_q;

endmodule

// File: tb/tb_vlcenc.sv
// Bench for vlcenc: bit-queue reference model, word scoreboard, directed and random token streams.
// Build with or without +define+VLCENC_SHORTCODE_EN.
module tb_vlcenc;
  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [1:0]  dbg_state;
  logic [5:0]  dbg_fill;
  logic [15:0] dbg_pred;

  vlcenc_if bus();

  vlcenc dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .bus       (bus.slave),
    .dbg_state (dbg_state),
    .dbg_fill  (dbg_fill),
    .dbg_pred  (dbg_pred)
  );

  always #5 clk = ~clk;

  int          vectors = 0;
  int          miscompares = 0;
  logic [15:0] exp_q[$];
  logic [15:0] mdl_log[$];
  bit          bitq[$];
  int          pred = 0;
  bit          rand_rdy = 0;
  int          pfx_code[12] = '{4, 0, 1, 5, 6, 14, 30, 62, 126, 254, 510, 511};
  int          pfx_len[12]  = '{3, 2, 2, 3, 3, 4, 5, 6, 7, 8, 9, 9};

  // ---------------- scoreboard helpers ----------------
  function automatic void check(string name, int act, int req);
    vectors++;
    if (act != req) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
    end
  endfunction

  function automatic void fail(string name);
    vectors++;
    miscompares++;
    $display("FAIL %s: bound expired at %0t", name, $time);
  endfunction

  // ---------------- reference model: a plain bit stream ----------------
  function automatic void push_bits(int v, int n);
    logic [15:0] w;
    for (int i = n - 1; i >= 0; i--) bitq.push_back(v[i]);
    while (bitq.size() >= 16) begin
      w = 16'd0;
      for (int i = 0; i < 16; i++) w = {w[14:0], bitq.pop_front()};
      exp_q.push_back(w);
    end
  endfunction

  function automatic void model_dc(int v);
    int diff, m, size;
    diff = v - pred;
    if (diff > 2047) diff = 2047;
    if (diff < -2047) diff = -2047;
    pred = v;
    m = (diff < 0) ? -diff : diff;
    size = 0;
    while (m > 0) begin size++; m = m / 2; end
    push_bits(pfx_code[size], pfx_len[size]);
    push_bits((diff > 0) ? diff : diff + (1 << size) - 1, size);
  endfunction

  function automatic void model_ac(int v, int run);
    int lev, mag;
    lev = v;
    if (lev > 2047) lev = 2047;
    if (lev < -2047) lev = -2047;
    if (lev == 0) lev = 1;
    mag = (lev < 0) ? -lev : lev;
`ifdef VLCENC_SHORTCODE_EN
    if (run == 0 && mag == 1) begin push_bits(6 + (lev < 0 ? 1 : 0), 3); return; end
    if (run == 1 && mag == 1) begin push_bits(6 + (lev < 0 ? 1 : 0), 4); return; end
    if (run == 0 && mag == 2) begin push_bits(8 + (lev < 0 ? 1 : 0), 5); return; end
`endif
    push_bits(1, 6);
    push_bits(run, 6);
    push_bits(lev & 32'hFFF, 12);
    if (mag > 4096) $display("unreachable level magnitude");
  endfunction

  function automatic void model_pad();
    if (bitq.size() != 0) push_bits(0, 16 - bitq.size());
  endfunction

  function automatic void model_clear();
    bitq.delete();
    exp_q.delete();
    pred = 0;
  endfunction

  // ---------------- driver tasks (start and end at a falling edge) ----------------
  task automatic wait_rdy(input string name);
    int t = 0;
    while (!bus.h_rdy && t < 1000) begin @(negedge clk); t++; end
    if (!bus.h_rdy) fail(name);
  endtask

  task automatic accept_token(input int kind, input int val, input int run);
    logic [15:0]        raw;
    logic signed [15:0] sv;
    raw = val[15:0];
    sv  = raw;
    wait_rdy("accept_wait");
    bus.h_en  = 1'b1;
    bus.h_val = raw;
    bus.h_len = run[5:0];
    bus.h_end = (kind == 2);
    bus.h_dc  = (kind == 1);
    if (kind == 2)      push_bits(2, 2);
    else if (kind == 1) model_dc(int'(sv));
    else                model_ac(int'(sv), run);
    @(negedge clk);
    bus.h_en  = 1'b0;
    bus.h_end = 1'b0;
    bus.h_dc  = 1'b0;
  endtask

  task automatic wait_idle(output int lat);
    lat = 0;
    while (!bus.h_rdy && lat < 1000) begin @(negedge clk); lat++; end
    if (!bus.h_rdy) fail("idle_wait");
  endtask

  task automatic send(input int kind, input int val, input int run);
    int lat;
    accept_token(kind, val, run);
    wait_idle(lat);
  endtask

  task automatic do_flush();
    int lat;
    wait_rdy("flush_wait");
    bus.flush = 1'b1;
    model_pad();
    @(negedge clk);
    bus.flush = 1'b0;
    wait_idle(lat);
  endtask

  task automatic do_dcclr();
    wait_rdy("dcclr_wait");
    bus.dc_clr = 1'b1;
    pred = 0;
    @(negedge clk);
    bus.dc_clr = 1'b0;
  endtask

  task automatic set_ordy(input logic v);
    @(posedge clk);
    #1 bus.o_rdy = v;
    @(negedge clk);
  endtask

  task automatic drain();
    int t = 0;
    rand_rdy = 0;
    set_ordy(1'b1);
    while (exp_q.size() != 0 && t < 2000) begin @(negedge clk); t++; end
    if (exp_q.size() != 0) fail("drain");
    @(negedge clk);
    check("fill_residual", int'(dbg_fill), bitq.size());
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int lat, op, v, run;
    bus.h_en = 1'b0; bus.h_val = 16'd0; bus.h_len = 6'd0; bus.h_end = 1'b0;
    bus.h_dc = 1'b0; bus.dc_clr = 1'b0; bus.flush = 1'b0; bus.o_rdy = 1'b1;

    fork
      forever begin
        logic [15:0] w;
        @(negedge clk);
        if (reset_n && bus.o_valid && bus.o_rdy) begin
          if (exp_q.size() == 0) fail("unexpected_word");
          else begin
            w = exp_q.pop_front();
            mdl_log.push_back(w);
            check("o_data", int'(bus.o_data), int'(w));
          end
        end
      end
      forever begin
        @(posedge clk);
        #1;
        if (rand_rdy) bus.o_rdy = ($urandom_range(0, 3) != 0);
      end
      begin
        #500000;
        $display("FAIL watchdog: run did not complete");
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares + 1);
        $fatal(1, "watchdog");
      end
    join_none

    // reset state
    repeat (3) @(negedge clk);
    check("rst_h_rdy", int'(bus.h_rdy), 0);
    check("rst_o_valid", int'(bus.o_valid), 0);
    check("rst_o_data", int'(bus.o_data), 0);
    check("rst_fill", int'(dbg_fill), 0);
    check("rst_state", int'(dbg_state), 0);
    reset_n = 1'b1;
    check("rel_h_rdy_before_edge", int'(bus.h_rdy), 0);
    @(negedge clk);
    check("rel_h_rdy_after_edge", int'(bus.h_rdy), 1);

    // DC -1, AC (0,-3), EOB, flush; two-cycle busy window per token
    mdl_log.delete();
    accept_token(1, -1, 0); wait_idle(lat); check("lat_dc", lat, 2);
    accept_token(0, -3, 0); wait_idle(lat); check("lat_ac", lat, 2);
    accept_token(2, 0, 0);  wait_idle(lat); check("lat_end", lat, 2);
    do_flush();
    drain();
    check("t1_pred", int'(dbg_pred), 16'hFFFF);
    check("t1_nwords", mdl_log.size(), 2);
    check("t1_w0", int'(mdl_log[0]), 16'h0081);
    check("t1_w1", int'(mdl_log[1]), 16'hFFB0);

    // short code vs escape sequence
    do_dcclr();
    mdl_log.delete();
    send(1, 0, 0); send(0, 1, 0); send(0, -1, 1); send(2, 0, 0);
    do_flush();
    drain();
`ifdef VLCENC_SHORTCODE_EN
    check("t2_nwords", mdl_log.size(), 1);
    check("t2_w0", int'(mdl_log[0]), 16'h99E0);
`else
    check("t2_nwords", mdl_log.size(), 4);
    check("t2_w0", int'(mdl_log[0]), 16'h8080);
    check("t2_w1", int'(mdl_log[1]), 16'h0020);
    check("t2_w2", int'(mdl_log[2]), 16'h83FF);
    check("t2_w3", int'(mdl_log[3]), 16'hF000);
`endif

    // DC prediction chain 100, 100, 90
    do_dcclr();
    mdl_log.delete();
    send(1, 100, 0); send(1, 100, 0); send(1, 90, 0);
    check("t3_pred", int'(dbg_pred), 90);
    do_flush();
    drain();
    check("t3_w0", int'(mdl_log[0]), 16'hFB24);
    check("t3_w1", int'(mdl_log[1]), 16'hCA00);

    // backpressure: accumulator fills to 48, third token stalls in APPEND
    set_ordy(1'b0);
    send(0, 100, 5); send(0, 100, 5);
    check("t4_fill_full", int'(dbg_fill), 48);
    check("t4_o_valid", int'(bus.o_valid), 1);
    accept_token(0, -100, 5);
    repeat (4) @(negedge clk);
    check("t4_stall_h_rdy", int'(bus.h_rdy), 0);
    check("t4_stall_state", int'(dbg_state), 2);
    check("t4_stall_fill", int'(dbg_fill), 48);
    drain();
    check("t4_idle_after", int'(bus.h_rdy), 1);
    do_flush();
    drain();

    // AC level and DC diff saturation
    mdl_log.delete();
    send(0, 32'h7FFF, 0); do_flush(); drain();
    send(0, 32'h8000, 0); do_flush(); drain();
    check("t5_w0", int'(mdl_log[0]), 16'h0407);
    check("t5_w1", int'(mdl_log[1]), 16'hFF00);
    check("t5_w2", int'(mdl_log[2]), 16'h0408);
    check("t5_w3", int'(mdl_log[3]), 16'h0100);
    do_dcclr();
    mdl_log.delete();
    send(1, 32'h7FFF, 0); send(1, 32'h8000, 0); do_flush(); drain();
    check("t5_pred", int'(dbg_pred), 16'h8000);
    check("t5_dc_w0", int'(mdl_log[0]), 16'hFFFF);
    check("t5_dc_w1", int'(mdl_log[1]), 16'hFFF8);
    check("t5_dc_w2", int'(mdl_log[2]), 16'h0000);

    // random token stream with random consumer stalls
    rand_rdy = 1;
    repeat (300) begin
      op = int'($urandom_range(0, 19));
      case ($urandom_range(0, 2))
        0:       v = int'($urandom_range(0, 10)) - 5;
        1:       v = int'($urandom_range(0, 4000)) - 2000;
        default: v = int'($urandom_range(0, 65535));
      endcase
      run = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 63)) : int'($urandom_range(0, 2));
      if (op == 0)      do_flush();
      else if (op == 1) do_dcclr();
      else if (op < 5)  send(2, 0, 0);
      else if (op < 10) send(1, v, 0);
      else              send(0, v, run);
    end
    do_flush();
    drain();

    // reset in the middle of a stalled APPEND with 30 bits held
    set_ordy(1'b0);
    do_dcclr();
    send(1, 0, 0); send(0, 7, 5); send(1, 1, 0);
    check("t6_fill30", int'(dbg_fill), 30);
    accept_token(0, 9, 5);
    repeat (3) @(negedge clk);
    check("t6_state_append", int'(dbg_state), 2);
    reset_n = 1'b0;
    #1;
    check("t6_rst_o_valid", int'(bus.o_valid), 0);
    check("t6_rst_h_rdy", int'(bus.h_rdy), 0);
    check("t6_rst_fill", int'(dbg_fill), 0);
    model_clear();
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    set_ordy(1'b1);
    mdl_log.delete();
    send(1, 0, 0);
    do_flush();
    drain();
    check("t6_nwords", mdl_log.size(), 1);
    check("t6_w0", int'(mdl_log[0]), 16'h8000);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
